// File: rtl/usb_audio_i2s_tx.sv
// Philips I2S transmitter for the USB audio path: 1-deep pending sample, Bresenham BCLK divider.
// Optional macro USB_AUDIO_I2S_UNDERRUN_MUTE_EN: on underrun, send silence instead of repeating the last sample.
module usb_audio_i2s_tx #(
  parameter int unsigned CLK_HZ           = 60000000,
  parameter int unsigned FS_HZ            = 48000,
  parameter int unsigned IN_OFFSET_BINARY = 1
) (
  input  logic        clk,
  input  logic        usb_rstn,
  input  logic [15:0] in_lch,
  input  logic [15:0] in_rch,
  input  logic        in_valid,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sd,
  output logic [15:0] underrun_cnt,
  output logic [15:0] overrun_cnt
);

  // Two BCLK edges per bit, 64 bits per frame.
  localparam logic [32:0] ACC_INC  = 33'(FS_HZ) * 33'd128;
  localparam logic [32:0] ACC_MOD  = 33'(CLK_HZ);
  localparam logic        CONV_MSB = (IN_OFFSET_BINARY != 0);

  logic [31:0] acc;
  logic [32:0] acc_sum;
  logic [31:0] acc_nxt;
  logic        tick;
  logic        bclk_fall;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_cnt_nxt;
  logic        frame_load;
  logic [4:0]  slot_nxt;
  logic [3:0]  sd_idx;
  logic [15:0] hold_ch;
  logic        sd_nxt;

  logic        pend_valid;
  logic [15:0] pend_l;
  logic [15:0] pend_r;
  logic [15:0] hold_l;
  logic [15:0] hold_r;

  function automatic logic [15:0] conv(input logic [15:0] s);
    return {s[15] ^ CONV_MSB, s[14:0]};
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    acc_sum     = {1'b0, acc} + ACC_INC;
    tick        = (acc_sum >= ACC_MOD);
    acc_nxt     = tick ? 32'(acc_sum - ACC_MOD) : acc_sum[31:0];
    bclk_fall   = tick & i2s_bclk;
    bit_cnt_nxt = bit_cnt + 6'd1;
    frame_load  = bclk_fall && (bit_cnt_nxt == 6'd0);
    // Data for the slot being entered; slot 1 carries the MSB, one BCLK after LRCK moves.
    slot_nxt    = bit_cnt_nxt[4:0];
    hold_ch     = bit_cnt_nxt[5] ? hold_r : hold_l;
    sd_idx      = 4'(5'd16 - slot_nxt);
    sd_nxt      = 1'b0;
    if (slot_nxt >= 5'd1 && slot_nxt <= 5'd16)
      sd_nxt = hold_ch[sd_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      acc      <= '0;
      bit_cnt  <= '0;
      i2s_bclk <= 1'b0;
      i2s_lrck <= 1'b0;
      i2s_sd   <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if (tick)
        i2s_bclk <= ~i2s_bclk;
      if (bclk_fall) begin
        bit_cnt  <= bit_cnt_nxt;
        i2s_lrck <= bit_cnt_nxt[5];
        i2s_sd   <= sd_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      pend_valid   <= 1'b0;
      pend_l       <= '0;
      pend_r       <= '0;
      hold_l       <= '0;
      hold_r       <= '0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      if (frame_load) begin
        if (pend_valid) begin
          hold_l <= conv(pend_l);
          hold_r <= conv(pend_r);
        end else begin
          if (underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
`ifdef USB_AUDIO_I2S_UNDERRUN_MUTE_EN
          hold_l <= '0;
          hold_r <= '0;
`endif
        end
      end
      // A sample arriving on the load cycle simply becomes the next pending one.
      if (in_valid) begin
        pend_l <= in_lch;
        pend_r <= in_rch;
        if (pend_valid && !frame_load && overrun_cnt != 16'hFFFF)
          overrun_cnt <= overrun_cnt + 16'd1;
      end
      pend_valid <= in_valid | (pend_valid & ~frame_load);
    end
  end

endmodule

// File: tb/tb_usb_audio_i2s_tx.sv
// Directed self-checking bench for usb_audio_i2s_tx: rate, data, underrun, overrun, load collision, reset.
`timescale 1ns/1ps
module tb_usb_audio_i2s_tx;

  localparam longint CLK_HZ = 60000000;
  localparam longint INC    = 6144000;

  logic        clk = 1'b0;
  logic        usb_rstn = 1'b0;
  logic [15:0] in_lch = '0;
  logic [15:0] in_rch = '0;
  logic        in_valid = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sd;
  logic [15:0] underrun_cnt;
  logic [15:0] overrun_cnt;

  int checks = 0;
  int errors = 0;

  usb_audio_i2s_tx dut (
    .clk          (clk),
    .usb_rstn     (usb_rstn),
    .in_lch       (in_lch),
    .in_rch       (in_rch),
    .in_valid     (in_valid),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sd       (i2s_sd),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 64-slot frame: MSB in slot 1 (left) and slot 33 (right), everything else zero.
  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] f;
    f = '0;
    for (int p = 1; p <= 16; p++) begin
      f[p]      = l[16-p];
      f[32 + p] = r[16-p];
    end
    return f;
  endfunction

  // Frame capture: sd and lrck sampled at each BCLK rise, slot advanced on each BCLK fall.
  logic [5:0]  slot = '0;
  logic        prev_b = 1'b0;
  logic [63:0] cur_f = '0;
  logic [63:0] last_f = '0;
  int          frame_cnt = 0;
  int          lrck_bad = 0;

  always @(negedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      slot   <= '0;
      prev_b <= 1'b0;
    end else begin
      if (i2s_bclk && !prev_b) begin
        cur_f[slot] <= i2s_sd;
        if (i2s_lrck !== slot[5])
          lrck_bad <= lrck_bad + 1;
      end
      if (!i2s_bclk && prev_b) begin
        if (slot == 6'd63) begin
          last_f    <= cur_f;
          frame_cnt <= frame_cnt + 1;
        end
        slot <= slot + 6'd1;
      end
      prev_b <= i2s_bclk;
    end
  end

  // Rate measurement, active only during the free-running window.
  logic rate_en = 1'b0;
  logic r_prev_b = 1'b0;
  logic r_prev_l = 1'b0;
  logic run_seen = 1'b0;
  int   run_len = 0;
  int   rise_cnt = 0;
  int   lr_rise = 0;
  int   lr_fall = 0;
  int   width_bad = 0;

  always @(negedge clk) begin
    if (rate_en) begin
      if (i2s_bclk != r_prev_b) begin
        if (run_seen && (run_len < 9 || run_len > 10))
          width_bad <= width_bad + 1;
        run_seen <= 1'b1;
        run_len  <= 1;
        if (i2s_bclk)
          rise_cnt <= rise_cnt + 1;
      end else begin
        run_len <= run_len + 1;
      end
      if (i2s_lrck && !r_prev_l) lr_rise <= lr_rise + 1;
      if (!i2s_lrck && r_prev_l) lr_fall <= lr_fall + 1;
      r_prev_b <= i2s_bclk;
      r_prev_l <= i2s_lrck;
    end
  end

  // Independent divider model, used only to find the clock of a frame load.
  longint m_acc = 0;
  always @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn)
      m_acc <= 0;
    else if (m_acc + INC >= CLK_HZ)
      m_acc <= m_acc + INC - CLK_HZ;
    else
      m_acc <= m_acc + INC;
  end

  task automatic pulse(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    in_lch   = l;
    in_rch   = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int start;
    start = frame_cnt;
    for (int i = 0; i < 3000 && frame_cnt == start; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_done"}, frame_cnt != start, 1);
  endtask

  task automatic wait_slot(input logic [5:0] s, input logic need_high, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = (slot == s) && (!need_high || i2s_bclk);
    end
    check({tag, "_reached"}, hit, 1);
  endtask

  logic [63:0] exp_rep;
  logic        fired;
  int          start_fc;

  initial begin
`ifdef USB_AUDIO_I2S_UNDERRUN_MUTE_EN
    exp_rep = '0;
`else
    exp_rep = exp_frame(16'h25A5, 16'hDA5A);
`endif

    // Reset state
    #23;
    check("rst_bclk", i2s_bclk, 0);
    check("rst_lrck", i2s_lrck, 0);
    check("rst_sd", i2s_sd, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_overrun", overrun_cnt, 0);

    // Free-running rate over exactly 60000 clocks, no input
    @(negedge clk);
    usb_rstn = 1'b1;
    rate_en  = 1'b1;
    repeat (60000) @(posedge clk);
    #7;
    rate_en = 1'b0;
    check("rate_bclk_rises", rise_cnt, 3072);
    check("rate_lrck_rises", lr_rise, 48);
    check("rate_lrck_falls", lr_fall, 48);
    check("rate_width_bad", width_bad, 0);
    check("rate_frames", frame_cnt, 48);
    check("rate_underrun", underrun_cnt, 48);

    // Offset-binary data: C000 -> 4000, 7FFF -> FFFF
    pulse(16'hC000, 16'h7FFF);
    wait_frame("data_pre");
    wait_frame("data");
    check("data_frame", last_f, exp_frame(16'h4000, 16'hFFFF));
    check("data_underrun", underrun_cnt, 49);

    // Overrun: second sample replaces the first within one frame
    pulse(16'h8001, 16'h0000);
    repeat (50) @(negedge clk);
    pulse(16'h8002, 16'h1234);
    #1;
    check("ovr_count", overrun_cnt, 1);
    wait_frame("ovr_pre");
    wait_frame("ovr");
    check("ovr_frame", last_f, exp_frame(16'h0002, 16'h9234));
    check("ovr_underrun", underrun_cnt, 50);

    // in_valid on the exact frame-load clock, with another sample already pending
    pulse(16'h1111, 16'h2222);
    wait_slot(6'd63, 1'b1, "sim_slot63");
    fired = 1'b0;
    for (int i = 0; i < 30 && !fired; i++) begin
      if (m_acc + INC >= CLK_HZ) begin
        start_fc = frame_cnt;
        in_lch   = 16'h8123;
        in_rch   = 16'h0456;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("sim_load_edge", frame_cnt, start_fc + 1);
        fired = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    check("sim_fired", fired, 1);
    check("sim_overrun", overrun_cnt, 1);
    check("sim_underrun", underrun_cnt, 50);
    wait_frame("sim_s1");
    check("sim_s1_frame", last_f, exp_frame(16'h9111, 16'hA222));
    wait_frame("sim_s2");
    check("sim_s2_frame", last_f, exp_frame(16'h0123, 16'h8456));
    check("sim_s2_underrun", underrun_cnt, 51);
    check("sim_s2_overrun", overrun_cnt, 1);

    // Reset in the middle of a frame
    wait_slot(6'd20, 1'b0, "mid_slot20");
    #2;
    usb_rstn = 1'b0;
    #1;
    check("mid_bclk", i2s_bclk, 0);
    check("mid_lrck", i2s_lrck, 0);
    check("mid_sd", i2s_sd, 0);
    check("mid_underrun", underrun_cnt, 0);
    check("mid_overrun", overrun_cnt, 0);
    repeat (3) @(negedge clk);
    usb_rstn = 1'b1;

    // Underrun: one sample, then three frames without input
    repeat (20) @(negedge clk);
    pulse(16'hA5A5, 16'h5A5A);
    wait_frame("und_f0");
    check("und_f0_zero", last_f, 64'd0);
    check("und_f0_count", underrun_cnt, 0);
    wait_frame("und_f1");
    check("und_f1_frame", last_f, exp_frame(16'h25A5, 16'hDA5A));
    wait_frame("und_f2");
    check("und_f2_frame", last_f, exp_rep);
    wait_frame("und_f3");
    check("und_f3_frame", last_f, exp_rep);
    check("und_count", underrun_cnt, 3);
    wait_frame("und_f4");
    check("und_f4_frame", last_f, exp_rep);
    check("und_overrun", overrun_cnt, 0);

    check("lrck_alignment", lrck_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_audio_i2s_tx.md
Name: usb_audio_i2s_tx

Overview:
Downstream stage of the USB audio PCM ping-pong buffer. Takes one stereo 16-bit sample per 48 kHz strobe and holds it in a 1-deep pending register. Serialises the sample as standard Philips I2S (64 BCLK per frame, 32 slots per channel) to an external DAC. BCLK/LRCK are derived from the 60 MHz system clock with a fractional (Bresenham) divider, so the average rate is exact and no MCLK PLL is needed.

Parameters:
CLK_HZ, 60000000, system clock frequency.
FS_HZ, 48000, audio frame rate; BCLK = 64*FS_HZ.
IN_OFFSET_BINARY, 1, 1 = input samples are offset-binary (MSB inverted) and are converted to two's complement by inverting bit 15; 0 = pass through unchanged.

Ports:
clk  in  1  system clock, 60 MHz
usb_rstn  in  1  asynchronous, active-low reset
in_lch  in  16  left sample, sampled when in_valid=1
in_rch  in  16  right sample, sampled when in_valid=1
in_valid  in  1  single-cycle sample strobe (~48 kHz)
i2s_bclk  out  1  bit clock, registered
i2s_lrck  out  1  word select, 0 = left, 1 = right; registered
i2s_sd  out  1  serial data, MSB first; registered
underrun_cnt  out  16  frames started with no new pending sample; saturates at FFFF
overrun_cnt  out  16  samples overwritten before use; saturates at FFFF

Behaviour:
- Reset (usb_rstn=0, async): bclk=0, lrck=0, sd=0, acc=0, bit_cnt=0, pending empty, pending and hold data = 0, both counters = 0. Reset mid-frame aborts the frame immediately. No glitch beyond the async clear.
- Divider: 32-bit acc.
  - Each clk: if acc + 2*64*FS_HZ >= CLK_HZ, then acc <= acc + 2*64*FS_HZ - CLK_HZ and tick=1.
  - Otherwise acc <= acc + 2*64*FS_HZ and tick=0.
  - Each tick toggles bclk. Default gives 6144 ticks per 60000 clk (exact).
- Falling edge (tick with bclk=1):
  - bit_cnt (6 bits) increments, wrapping 63->0.
  - lrck <= new bit_cnt[5].
  - sd updated.
  - All three outputs change in the same clk cycle as bclk falls.
- Slot p = bit_cnt[4:0]:
  - p=0: sd=0.
  - p=1..16: sd = hold_ch[16-p], where hold_ch is hold_l when bit_cnt[5]=0 and hold_r otherwise.
  - p=17..31: sd=0.
  - This places the MSB one BCLK after the LRCK edge (I2S).
- Frame load, on the falling edge where bit_cnt becomes 0:
  - If pending is valid: hold <= converted pending; pending cleared.
  - Otherwise: hold is unchanged (last sample repeats) and underrun_cnt++.
- Input rules:
  - in_valid with pending empty: latch the sample; pending valid.
  - in_valid with pending already valid and no load in the same cycle: overwrite with the newer sample; overrun_cnt++.
  - in_valid in the same cycle as a frame load: the old pending goes to hold and the new sample becomes pending. No overrun.
- Conversion is applied at load time: bit15 ^= IN_OFFSET_BINARY.
- Counters saturate; they are never cleared except by reset.
- Latency from in_valid to its first data bit: at most one full frame plus 1 BCLK.

Optional Feature:
Macro USB_AUDIO_I2S_UNDERRUN_MUTE_EN.
- Defined: on underrun, hold_l and hold_r are set to 16'h0000 (silence) instead of repeating. underrun_cnt still increments.
- Undefined: the last sample repeats (default).

Test Plan:
- Rate check: reset release, run 60000 clk, no input -> exactly 3072 bclk rising edges and 48 full LRCK periods; bclk high/low widths are 9 or 10 clk.
- Data check: in_valid with in_lch=16'hC000, in_rch=16'h7FFF (offset-binary), IN_OFFSET_BINARY=1 -> next frame, left slots 1..16 = 0100_0000_0000_0000, right slots = 1111_1111_1111_1111, slots 0 and 17..31 = 0.
- Underrun: one sample 16'hA5A5/16'h5A5A then none for 3 frames -> the same bits repeat 3 more frames and underrun_cnt=3. With the macro defined, sd=0 for those 3 frames, still count 3.
- Overrun: two in_valid (L=16'h8001 then 16'h8002) inside one frame -> overrun_cnt=1; left transmits 16'h0002.
- Simultaneous: in_valid asserted in the exact clk of the frame load -> overrun_cnt unchanged; the new sample transmits in the following frame.
- Reset mid-frame: assert usb_rstn=0 at bit_cnt=20 -> bclk/lrck/sd/counters go 0 asynchronously; after release the first frame starts at bit_cnt=0 with hold=0.
